// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and constants for the on-chip memory arbiter.
package onchip_mem_arb_pkg;

    // Master identifier: one bit selects between the two masters.
    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    // Read-return tag carried alongside each access through the memory pipeline.
    typedef struct packed {
        logic       valid;
        master_id_t id;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, id: M0};

    // Supported memory read latency, in enabled clocks.
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 4;

    function automatic bit mem_latency_legal(input int lat);
        return (lat >= MEM_LATENCY_MIN) && (lat <= MEM_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a grant lock for back-to-back bursts.
module rr_arb2
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       advance_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output master_id_t winner_o
);

    master_id_t last_winner_q, last_winner_d;
    logic       lock_valid_q,  lock_valid_d;
    master_id_t lock_owner_q,  lock_owner_d;

    // Pick the winner: a requesting lock owner first, then a lone requester, then round-robin.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        winner_o = M0;
        grant_o  = 2'b00;
        if (lock_valid_q && req_i[lock_owner_q]) begin
            winner_o = lock_owner_q;
        end else if (req_i == 2'b10) begin
            winner_o = M1;
        end else if (req_i == 2'b11) begin
            winner_o = ~last_winner_q;
        end
        if (req_i != 2'b00) begin
            grant_o[winner_o] = 1'b1;
        end
    end

    // Next state: remember the winner on issue; drop the lock once its owner goes idle.
    always_comb begin
        last_winner_d = last_winner_q;
        lock_valid_d  = lock_valid_q;
        lock_owner_d  = lock_owner_q;
        if (advance_i) begin
            last_winner_d = winner_o;
            lock_valid_d  = lock_i[winner_o];
            lock_owner_d  = winner_o;
        end else if (enable_i && lock_valid_q && !req_i[lock_owner_q]) begin
            lock_valid_d  = 1'b0;
        end
    end

    // Arbitration state register; reset favours m0 on the first tie.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            last_winner_q <= M1;
            lock_valid_q  <= 1'b0;
            lock_owner_q  <= M0;
        end else begin
            last_winner_q <= last_winner_d;
            lock_valid_q  <= lock_valid_d;
            lock_owner_q  <= lock_owner_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip memory between two Avalon-MM masters and
// routes fixed-latency read data back to the master that issued the read.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int BE_W        = DATA_W / 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam bit LATENCY_OK = mem_latency_legal(MEM_LATENCY);

    generate
        if (!LATENCY_OK) begin : g_bad_latency
            $error("onchip_mem_arbiter: MEM_LATENCY must lie in 1..4");
        end
    endgenerate

    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] grant;
    master_id_t winner;
    logic       issue;
    logic       sel_m1;
    logic       win_read;
    logic       win_write;
    logic       ret_en;
    tag_t       stage0_d;
    tag_t       tag_out;
    tag_t       tag_q [MEM_LATENCY];

    assign req  = {m1_read | m1_write, m0_read | m0_write};
    assign lock = {m1_lock, m0_lock};

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .lock_i    (lock),
        .advance_i (issue),
        .enable_i  (mem_clken),
        .grant_o   (grant),
        .winner_o  (winner)
    );

    // The memory is frozen while a reset request is pending; nothing issues during reset.
    assign mem_clken = ~reset_req;
    assign issue     = (|grant) & mem_clken & ~reset;
    assign sel_m1    = issue & (winner == M1);

    // Route the winning master's access to the memory port (m0 when idle).
    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        win_read       = m0_read;
        win_write      = m0_write;
        if (sel_m1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            win_read       = m1_read;
            win_write      = m1_write;
        end
    end

    assign mem_chipselect = issue;
    assign mem_write      = issue & win_write;

    assign m0_waitrequest = req[0] & ~(issue & (winner == M0));
    assign m1_waitrequest = req[1] & ~sel_m1;

    // A read with write also high is illegal: the write wins and no tag is launched.
    assign stage0_d = '{valid: issue & win_read & ~win_write, id: winner};

    // Tag pipeline mirrors the memory read latency and stalls with the memory clock enable.
    always_ff @(posedge clk) begin
        // NOTE: the tag stages are reset (unlike a data RAM) because a stale valid would fake a read return.
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else if (mem_clken) begin
            tag_q[0] <= stage0_d;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Returns are shown only on enabled cycles so each lasts exactly one clock.
    assign tag_out          = tag_q[MEM_LATENCY-1];
    assign ret_en           = tag_out.valid & mem_clken & ~reset;
    assign m0_readdatavalid = ret_en & (tag_out.id == M0);
    assign m1_readdatavalid = ret_en & (tag_out.id == M1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    a_m0_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
    a_m1_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));
    a_rdv_onehot:      assert property (@(posedge clk) !(m0_readdatavalid && m1_readdatavalid));

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port 8192x32 on-chip memory between two Avalon-MM style masters.
  - m0: Nios II data master.
  - m1: convolution-filter pixel engine.
- Two-way round-robin arbitration, with an optional lock for back-to-back bursts.
- Returns read data with a fixed latency and routes readdatavalid to the master that issued the read.
- Sits between the system interconnect and the memory slave port. It drives the memory's address, byteenable, chipselect, write, writedata and clken inputs.

Parameters:
- ADDR_W, 13, word address width (8192 words).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- MEM_LATENCY, 1, memory read latency in enabled clocks; legal range 1..4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset-request hold; freezes the memory and all arbitration
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_lock  in  1  master 0 keeps the grant after this access
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same set and directions as m0_*, for master 1
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  BE_W  to memory
- mem_chipselect  out  1  to memory
- mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory
- mem_clken  out  1  memory clock enable
- mem_readdata  in  DATA_W  from memory

Behaviour:
- Request definition: reqN = mN_read | mN_write. A request with read and write both high is illegal; the write wins, the read is dropped, and a simulation assertion fires.
- Per-cycle grant, combinational from requests, last_winner (reg) and lock_owner (reg):
  - If lock_owner is valid and its owner is requesting, the owner wins.
  - Otherwise a single requester wins.
  - Otherwise, if both request, the master that is not last_winner wins.
- Issue when grant is given and mem_clken=1:
  - mN_waitrequest=0 for the winner; 1 for any non-winning requester; 0 when not requesting.
  - Memory outputs are a combinational mux of the winner's signals.
  - mem_chipselect = issue.
  - mem_write = issue & winner write.
  - With no issue, mem_address/byteenable/writedata hold the m0 values (don't-care), chipselect=0, write=0.
- Register updates on issue:
  - last_winner <= winner.
  - lock_owner <= winner if the winner's lock is set, else invalid.
  - If the lock owner stops requesting, the lock clears the next cycle.
- mem_clken = ~reset_req. While reset_req=1:
  - No issue; every requester sees waitrequest=1.
  - The tag pipeline and lock hold their values (the memory is frozen too, so latency stays consistent).
- Read return: a tag shift register, MEM_LATENCY deep, of {valid,id}.
  - Stage 0 is loaded with {issue & read, winner}.
  - It advances only when mem_clken=1.
  - At the last stage, m<id>_readdatavalid=1 for exactly one clk.
  - mN_readdata = mem_readdata for both masters (broadcast); only the valid qualifies it.
- Throughput and latency:
  - One access per cycle, fully pipelined.
  - A read issued in cycle t returns in cycle t+MEM_LATENCY (with no reset_req).
  - Writes have no response.
- Reset (sync) clears:
  - last_winner <= 1, so m0 wins the first tie.
  - lock_owner <= invalid.
  - All tag stages <= invalid, so readdatavalid=0 from the following cycle.
  - Reads in flight when reset asserts are discarded and never returned.
- During reset=1: no issue, mem_chipselect=0, and every requester sees waitrequest=1.
- Both outputs carrying readdatavalid=1 in the same cycle is impossible by construction; assert it.

Decomposition:
- Package onchip_mem_arb_pkg:
  - Master ID type (1 bit) and constants M0=0, M1=1.
  - Tag record {valid, id}.
  - MEM_LATENCY legal-range check constant.
- One natural sub-module, rr_arb2: two-requester round-robin with lock.
  - Inputs: req[1:0], lock[1:0], advance.
  - Outputs: grant one-hot, winner id.
  - Holds last_winner and lock_owner.
- Muxing and the tag pipeline stay in the top.

Test Plan:
- Single master: m0 read at address 0x0010 while memory holds 0xDEADBEEF → m0_waitrequest=0, mem_chipselect=1 the same cycle, m0_readdatavalid=1 with 0xDEADBEEF one cycle later; m1_readdatavalid stays 0.
- Contention: m0 and m1 both hold continuous reads for 6 cycles after reset → grants alternate m0,m1,m0,m1,m0,m1; each readdatavalid pulse routes to the issuer, 1 cycle after issue.
- Lock: m1 writes 4 words (0x100..0x103, data 0x11..0x44) with m1_lock=1 while m0 requests → m0_waitrequest=1 for those 4 cycles, m0 granted on the 5th; a read-back shows 0x11..0x44.
- Byte enables: m0 writes 0xAABBCCDD to address 0x20 with byteenable=4'b0101 over 0x00000000 → read returns 0x00BB00DD.
- reset_req: assert reset_req for 3 cycles in the cycle right after an m1 read issue → mem_clken=0 and both waitrequests=1 throughout; m1_readdatavalid is delayed until the first cycle after release, with correct data.
- Reset mid-operation: pulse reset in the cycle after an m0 read issue → no readdatavalid; the first tie after reset is granted to m0.
